// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
// Contents: pipe_state_t (RUN/MEM_WAIT/HALTED), HALT_DRAIN (cycles to drain
// older instructions before entering HALTED).
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    HALTED   = 3'd2
  } pipe_state_t;

  localparam int unsigned HALT_DRAIN = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/sequencing controller.
// master: datapath side (drives hazard inputs, receives enables/flushes).
// slave : controller side (receives hazard inputs, drives enables/flushes,
//         state and performance counters).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 16
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_reg_dest;
  logic                  ex_is_load;
  logic                  branch_taken;
  logic                  mem_access;
  logic                  halt_req;
  logic                  resume;

  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_en;
  logic                  idex_flush;
  logic                  exmem_en;
  logic                  memwb_en;
  logic [2:0]            state_o;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_reg_dest, ex_is_load,
           branch_taken, mem_access, halt_req, resume,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, state_o, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_reg_dest, ex_is_load,
           branch_taken, mem_access, halt_req, resume,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, state_o, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Purely combinational load-use comparator: flags a Decode instruction that
// reads the destination of a load currently in Execute.
// Ports: id_rs1_i/id_rs2_i/id_uses_rs2_i (Decode sources), ex_reg_dest_i and
// ex_is_load_i (Execute load), load_use_c_o (combinational hazard flag).
module hazard_detect #(
  parameter int unsigned REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_reg_dest_i,
  input  logic                  ex_is_load_i,
  output logic                  load_use_c_o
);

  assign load_use_c_o = ex_is_load_i &&
                        ((ex_reg_dest_i == id_rs1_i) ||
                         (id_uses_rs2_i && (ex_reg_dest_i == id_rs2_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencing controller for the 16-bit five-stage pipeline. Drives
// the enable/flush pins of the PC and the four stage registers, handling
// RAM wait states, taken-branch flushes, load-use bubbles and halt/resume.
// Outputs are combinational from state, registers and inputs.
// Ports: clk, reset (async, active-high), bus (pipeline_hazard_ctrl_if.slave:
// hazard inputs in; stage enables/flushes, state_o, stall_cycles,
// flush_count out).
// Optional macro HAZARD_PERF_CNT_EN: when defined, stall_cycles and
// flush_count are saturating counters; otherwise both are tied to 0.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = 4,
  parameter int unsigned MEM_WAIT_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WAIT_MAX = (MEM_WAIT_CYCLES > HALT_DRAIN) ?
                                     MEM_WAIT_CYCLES : HALT_DRAIN;
  localparam int unsigned WCNT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned MEM_LOAD = (MEM_WAIT_CYCLES > 0) ?
                                     MEM_WAIT_CYCLES - 1 : 0;

  pipe_state_t       state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_ack_q, mem_ack_d;
  logic              mem_ack_set;

  logic load_use;
  logic mem_freeze;

  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
  logic exmem_en_c, memwb_en_c;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_reg_dest_i (bus.ex_reg_dest),
    .ex_is_load_i  (bus.ex_is_load),
    .load_use_c_o  (load_use)
  );

  // mem_ack suppresses a second freeze while the same access sits in Memory.
  assign mem_freeze = bus.mem_access && !mem_ack_q && (MEM_WAIT_CYCLES > 0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_ack_q  <= mem_ack_d;
    end
  end

  // Next-state and stage strobes
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_ack_set  = 1'b0;
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_en_c    = 1'b1;
    idex_flush_c = 1'b0;
    exmem_en_c   = 1'b1;
    memwb_en_c   = 1'b1;

    unique case (state_q)
      RUN: begin
        if (mem_freeze) begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          exmem_en_c = 1'b0;
          memwb_en_c = 1'b0;
          // A one-cycle wait completes in place; longer waits use MEM_WAIT.
          // wait_cnt is left alone in the one-cycle case so a halt drain
          // in progress keeps its count.
          if (MEM_WAIT_CYCLES == 1) begin
            mem_ack_set = 1'b1;
          end else begin
            wait_cnt_d = WCNT_W'(MEM_LOAD);
            state_d    = MEM_WAIT;
          end
        end else if (bus.branch_taken) begin
          // Younger load-use is irrelevant: its instruction is being flushed.
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          wait_cnt_d   = '0;
        end else if (load_use) begin
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
          wait_cnt_d   = '0;
        end else if (bus.halt_req) begin
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
          // Count drain cycles 0..HALT_DRAIN-1, then enter HALTED.
          if (wait_cnt_q >= WCNT_W'(HALT_DRAIN - 1)) begin
            state_d    = HALTED;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end else begin
          wait_cnt_d = '0;
        end
      end

      MEM_WAIT: begin
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        idex_en_c  = 1'b0;
        exmem_en_c = 1'b0;
        memwb_en_c = 1'b0;
        if (wait_cnt_q <= WCNT_W'(1)) begin
          mem_ack_set = 1'b1;
          wait_cnt_d  = '0;
          state_d     = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q - WCNT_W'(1);
        end
      end

      HALTED: begin
        pc_en_c   = 1'b0;
        ifid_en_c = 1'b0;
        idex_en_c = 1'b0;
        if (bus.resume) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Ack lives until the frozen access finally advances out of Memory.
    mem_ack_d = mem_ack_set | (mem_ack_q & ~exmem_en_c);
  end

  assign bus.pc_en      = pc_en_c;
  assign bus.ifid_en    = ifid_en_c;
  assign bus.ifid_flush = ifid_flush_c;
  assign bus.idex_en    = idex_en_c;
  assign bus.idex_flush = idex_flush_c;
  assign bus.exmem_en   = exmem_en_c;
  assign bus.memwb_en   = memwb_en_c;
  assign bus.state_o    = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_inc;
  logic             flush_inc;

  assign stall_inc = !pc_en_c && (state_q != HALTED);
  assign flush_inc = (state_q == RUN) && !mem_freeze && bus.branch_taken;

  // Saturating performance counters
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush_inc && (flush_q != '1)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_WAIT_CYCLES = 3).
// Strobe vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
// exmem_en, memwb_en}. Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned CNT_W      = 16;

  localparam logic [6:0] V_RUN    = 7'b1101011;
  localparam logic [6:0] V_BRANCH = 7'b1111111;
  localparam logic [6:0] V_STALL  = 7'b0001111;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_HALTED = 7'b0000011;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus_if ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W      (REG_ADDR_W),
    .MEM_WAIT_CYCLES (3),
    .CNT_W           (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [6:0] ctl;
  assign ctl = {bus_if.pc_en, bus_if.ifid_en, bus_if.ifid_flush, bus_if.idex_en,
                bus_if.idex_flush, bus_if.exmem_en, bus_if.memwb_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] ec(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return CNT_W'(v);
`else
    return (v == -1) ? CNT_W'(1) : CNT_W'(0);
`endif
  endfunction

  task automatic idle();
    bus_if.id_rs1       = 4'd1;
    bus_if.id_rs2       = 4'd2;
    bus_if.id_uses_rs2  = 1'b0;
    bus_if.ex_reg_dest  = 4'd9;
    bus_if.ex_is_load   = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.mem_access   = 1'b0;
    bus_if.halt_req     = 1'b0;
    bus_if.resume       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    #2;
    reset = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #3;
    checks++;
    if (bus_if.state_o !== 3'd0) begin
      errors++;
      $display("FAIL rst_state got %0d exp 0", bus_if.state_o);
    end
    checks++;
    if (ctl !== V_RUN) begin
      errors++;
      $display("FAIL rst_ctl got %b exp %b", ctl, V_RUN);
    end
    checks++;
    if (bus_if.stall_cycles !== ec(0) || bus_if.flush_count !== ec(0)) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d exp 0/0", bus_if.stall_cycles, bus_if.flush_count);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    next_cycle();
    bus_if.ex_is_load  = 1'b1;
    bus_if.ex_reg_dest = 4'd3;
    bus_if.id_rs1      = 4'd3;
    #1;
    checks++;
    if (ctl !== V_STALL) begin
      errors++;
      $display("FAIL lu_rs1 got %b exp %b", ctl, V_STALL);
    end
    next_cycle();
    checks++;
    if (bus_if.stall_cycles !== ec(1)) begin
      errors++;
      $display("FAIL lu_cnt1 got %0d exp %0d", bus_if.stall_cycles, ec(1));
    end
    // Load has moved on; the stalled instruction proceeds.
    bus_if.ex_is_load = 1'b0;
    #1;
    checks++;
    if (ctl !== V_RUN) begin
      errors++;
      $display("FAIL lu_release got %b exp %b", ctl, V_RUN);
    end
    next_cycle();
    bus_if.ex_is_load  = 1'b1;
    bus_if.ex_reg_dest = 4'd5;
    bus_if.id_rs1      = 4'd1;
    bus_if.id_rs2      = 4'd5;
    bus_if.id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (ctl !== V_STALL) begin
      errors++;
      $display("FAIL lu_rs2 got %b exp %b", ctl, V_STALL);
    end
    next_cycle();
    bus_if.id_uses_rs2 = 1'b0;
    #1;
    checks++;
    if (ctl !== V_RUN) begin
      errors++;
      $display("FAIL lu_rs2_unused got %b exp %b", ctl, V_RUN);
    end
    next_cycle();
    idle();
    checks++;
    if (bus_if.stall_cycles !== ec(2)) begin
      errors++;
      $display("FAIL lu_cnt2 got %0d exp %0d", bus_if.stall_cycles, ec(2));
    end
  endtask

  task automatic test_branch();
    do_reset();
    next_cycle();
    bus_if.branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== V_BRANCH) begin
      errors++;
      $display("FAIL br_flush got %b exp %b", ctl, V_BRANCH);
    end
    next_cycle();
    checks++;
    if (bus_if.flush_count !== ec(1)) begin
      errors++;
      $display("FAIL br_cnt1 got %0d exp %0d", bus_if.flush_count, ec(1));
    end
    // Branch plus a coincident load-use: flush wins, no stall.
    bus_if.ex_is_load  = 1'b1;
    bus_if.ex_reg_dest = 4'd3;
    bus_if.id_rs1      = 4'd3;
    #1;
    checks++;
    if (ctl !== V_BRANCH) begin
      errors++;
      $display("FAIL br_over_lu got %b exp %b", ctl, V_BRANCH);
    end
    next_cycle();
    idle();
    #1;
    checks++;
    if (bus_if.flush_count !== ec(2) || bus_if.stall_cycles !== ec(0)) begin
      errors++;
      $display("FAIL br_cnt2 got %0d/%0d exp %0d/%0d", bus_if.flush_count,
               bus_if.stall_cycles, ec(2), ec(0));
    end
    checks++;
    if (ctl !== V_RUN) begin
      errors++;
      $display("FAIL br_idle got %b exp %b", ctl, V_RUN);
    end
  endtask

  task automatic test_mem_wait();
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
    logic [6:0] exp_v  [4] = '{V_FREEZE, V_FREEZE, V_FREEZE, V_RUN};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      bus_if.mem_access = 1'b1;
      #1;
      checks++;
      if (ctl !== exp_v[c] || bus_if.state_o !== exp_st[c]) begin
        errors++;
        $display("FAIL mw_cyc%0d got %b/%0d exp %b/%0d", c, ctl, bus_if.state_o,
                 exp_v[c], exp_st[c]);
      end
    end
    next_cycle();
    bus_if.mem_access = 1'b0;
    #1;
    checks++;
    if (bus_if.stall_cycles !== ec(3) || ctl !== V_RUN) begin
      errors++;
      $display("FAIL mw_done got %0d/%b exp %0d/%b", bus_if.stall_cycles, ctl, ec(3), V_RUN);
    end
    // A fresh access freezes again.
    next_cycle();
    bus_if.mem_access = 1'b1;
    #1;
    checks++;
    if (ctl !== V_FREEZE) begin
      errors++;
      $display("FAIL mw_new got %b exp %b", ctl, V_FREEZE);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_branch_in_wait();
    logic [6:0] exp_v [4] = '{V_FREEZE, V_FREEZE, V_FREEZE, V_BRANCH};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      bus_if.mem_access   = 1'b1;
      bus_if.branch_taken = 1'b1;
      #1;
      checks++;
      if (ctl !== exp_v[c]) begin
        errors++;
        $display("FAIL bw_cyc%0d got %b exp %b", c, ctl, exp_v[c]);
      end
    end
    next_cycle();
    idle();
    #1;
    checks++;
    if (bus_if.flush_count !== ec(1) || bus_if.stall_cycles !== ec(3)) begin
      errors++;
      $display("FAIL bw_cnt got %0d/%0d exp %0d/%0d", bus_if.flush_count,
               bus_if.stall_cycles, ec(1), ec(3));
    end
    checks++;
    if (ctl !== V_RUN) begin
      errors++;
      $display("FAIL bw_after got %b exp %b", ctl, V_RUN);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      bus_if.halt_req = 1'b1;
      #1;
      checks++;
      if (ctl !== V_STALL || bus_if.state_o !== 3'd0) begin
        errors++;
        $display("FAIL hlt_drain%0d got %b/%0d exp %b/0", c, ctl, bus_if.state_o, V_STALL);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (ctl !== V_HALTED || bus_if.state_o !== 3'd2) begin
      errors++;
      $display("FAIL hlt_enter got %b/%0d exp %b/2", ctl, bus_if.state_o, V_HALTED);
    end
    next_cycle();
    bus_if.halt_req = 1'b0;
    bus_if.resume   = 1'b1;
    #1;
    checks++;
    if (ctl !== V_HALTED || bus_if.state_o !== 3'd2) begin
      errors++;
      $display("FAIL hlt_resume_cyc got %b/%0d exp %b/2", ctl, bus_if.state_o, V_HALTED);
    end
    checks++;
    if (bus_if.stall_cycles !== ec(3)) begin
      errors++;
      $display("FAIL hlt_cnt got %0d exp %0d", bus_if.stall_cycles, ec(3));
    end
    next_cycle();
    bus_if.resume = 1'b0;
    #1;
    checks++;
    if (ctl !== V_RUN || bus_if.state_o !== 3'd0) begin
      errors++;
      $display("FAIL hlt_run got %b/%0d exp %b/0", ctl, bus_if.state_o, V_RUN);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    next_cycle();
    bus_if.mem_access = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (bus_if.state_o !== 3'd1) begin
      errors++;
      $display("FAIL rmw_inwait got %0d exp 1", bus_if.state_o);
    end
    // Reset between edges; the datapath drops its access with the same reset.
    reset = 1'b1;
    bus_if.mem_access = 1'b0;
    #1;
    checks++;
    if (bus_if.state_o !== 3'd0 || ctl !== V_RUN) begin
      errors++;
      $display("FAIL rmw_async got %0d/%b exp 0/%b", bus_if.state_o, ctl, V_RUN);
    end
    checks++;
    if (bus_if.stall_cycles !== ec(0)) begin
      errors++;
      $display("FAIL rmw_cnt got %0d exp 0", bus_if.stall_cycles);
    end
    #1;
    reset = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (ctl !== V_RUN || bus_if.state_o !== 3'd0) begin
      errors++;
      $display("FAIL rmw_after got %b/%0d exp %b/0", ctl, bus_if.state_o, V_RUN);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_in_wait();
    test_halt();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 16-bit five-stage pipeline (Fetch, Decode, Execute, Memory, Writeback).
- Generates per-stage enable and flush strobes for the PC register and the four pipeline registers.
- Detects load-use hazards and taken branches resolved in Execute.
- Inserts wait states while the registered-output data RAM completes an access.
- Implements halt/resume.
- Sits beside the datapath and drives only enable/flush pins of existing stage registers.

Parameters:
REG_ADDR_W, 4, register-file address width
MEM_WAIT_CYCLES, 1, pipeline-freeze cycles per RAM access (0 = no wait)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs1  in  REG_ADDR_W  Decode source A address (instruction[3:0])
id_rs2  in  REG_ADDR_W  Decode source B address (instruction[7:4])
id_uses_rs2  in  1  Decode instruction reads rs2
ex_reg_dest  in  REG_ADDR_W  Execute-stage destination register
ex_is_load  in  1  Execute instruction reads RAM into a register
branch_taken  in  1  Execute resolved a taken jump/branch (drives PC mux)
mem_access  in  1  Memory-stage instruction accesses RAM (read or write)
halt_req  in  1  Decode holds a halt instruction
resume  in  1  leave HALTED
pc_en  out  1  PC register load enable
ifid_en  out  1  Fetch/Decode register enable
ifid_flush  out  1  Fetch/Decode register clear (sync)
idex_en  out  1  Decode/Execute register enable
idex_flush  out  1  Decode/Execute register clear (inserts bubble)
exmem_en  out  1  Execute/Memory register enable
memwb_en  out  1  Memory/Writeback register enable
state_o  out  3  current FSM state encoding
stall_cycles  out  CNT_W  cycles with pc_en=0 outside HALTED
flush_count  out  CNT_W  taken-branch flushes

Behaviour:
- Reset, async: state=RUN, wait_cnt=0, mem_ack=0, counters=0. Outputs settle to RUN defaults: all enables 1, flushes 0.
- Outputs are combinational from state, registers and inputs; no added latency.
- States: RUN=0, MEM_WAIT=1, HALTED=2.

RUN, evaluated in priority order:
1. mem_access && !mem_ack && MEM_WAIT_CYCLES>0 (memory freeze):
   - All enables 0.
   - If MEM_WAIT_CYCLES==1: set mem_ack and stay in RUN.
   - Otherwise: load wait_cnt=MEM_WAIT_CYCLES-1 and go to MEM_WAIT.
   - Total freeze is exactly MEM_WAIT_CYCLES cycles.
2. branch_taken:
   - pc_en=1 (loads target), ifid_flush=1, idex_flush=1, all other enables 1.
   - flush_count++.
   - A coincident load-use hazard is ignored, because its instruction is flushed.
3. Load-use: ex_is_load && (ex_reg_dest==id_rs1 || (id_uses_rs2 && ex_reg_dest==id_rs2)):
   - pc_en=0, ifid_en=0, idex_flush=1; exmem_en and memwb_en = 1.
   - Exactly one bubble. Re-evaluated the next cycle; the load has moved on by then, so there is no repeat.
4. halt_req:
   - pc_en=0, ifid_en=0, idex_flush=1; go to HALTED after older instructions drain (3 cycles, counted in wait_cnt).
5. Otherwise: all enables 1.

mem_ack handling:
- mem_ack clears on any cycle where exmem_en=1.
- It prevents re-freezing on the same access.

MEM_WAIT:
- All enables 0; wait_cnt decrements each cycle.
- When wait_cnt==1: set mem_ack and return to RUN.
- branch_taken and halt_req are held stable by the frozen stages and are serviced on return.

HALTED:
- pc_en=ifid_en=idex_en=0; exmem_en and memwb_en = 1 (drain).
- resume=1 returns to RUN on the next edge; the cycle in which resume is seen still reads as halted.

Counters:
- stall_cycles increments when pc_en==0 && state!=HALTED.
- Both counters saturate at all-ones.

Reset mid-MEM_WAIT or mid-halt: immediate return to RUN, counters cleared; the datapath is reset by the same signal.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cycles and flush_count are implemented as described.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - typedef enum logic [2:0] {RUN, MEM_WAIT, HALTED} pipe_state_t
  - localparam HALT_DRAIN = 3
- One natural sub-module, hazard_detect: purely combinational load-use comparator, reusable by a future forwarding unit.

Test Plan:
1. Load-use: ex_is_load=1, ex_reg_dest=3, id_rs1=3 for one cycle -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1.
2. Taken branch: branch_taken=1 one cycle -> ifid_flush=1, idex_flush=1, pc_en=1 that cycle; flush_count=1. Same stimulus plus a load-use match -> no stall.
3. Memory wait, MEM_WAIT_CYCLES=3, mem_access held 4 cycles -> all enables 0 for exactly 3 cycles, then 1; no second freeze for the same access.
4. Branch during MEM_WAIT -> no flush until the cycle after return to RUN, then a single flush.
5. halt_req -> HALTED after 3 cycles with pc_en=0 and exmem_en=1; resume -> RUN next edge, pc_en=1.
6. reset asserted mid-MEM_WAIT (asynchronously, between edges) -> state_o=0 and all enables 1 before the next clock edge.
